// File: rtl/chain_relax_sequencer_if.sv
// Host/controller and constraint-unit signal bundle for chain_relax_sequencer.
// slave = the sequencer, master = the host side that also hosts the constraint unit.
interface chain_relax_sequencer_if #(
    parameter int N_POINTS = 8,
    parameter int ITER_W   = 4
);
    localparam int IW = $clog2(N_POINTS);

    logic              load_valid;
    logic              load_ready;
    logic [IW-1:0]     load_idx;
    logic [31:0]       load_x;
    logic [31:0]       load_y;
    logic              start;
    logic [ITER_W-1:0] iterations;
    logic              busy;
    logic              done;
    logic [IW-1:0]     rd_idx;
    logic [31:0]       rd_x;
    logic [31:0]       rd_y;
    logic [31:0]       cu_up_x, cu_up_y, cu_x, cu_y, cu_down_x, cu_down_y;
    logic              cu_is_last;
    logic [31:0]       cu_x_enf, cu_y_enf;

    modport slave (
        input  load_valid, load_idx, load_x, load_y, start, iterations, rd_idx,
               cu_x_enf, cu_y_enf,
        output load_ready, busy, done, rd_x, rd_y,
               cu_up_x, cu_up_y, cu_x, cu_y, cu_down_x, cu_down_y, cu_is_last
    );

    modport master (
        output load_valid, load_idx, load_x, load_y, start, iterations, rd_idx,
               cu_x_enf, cu_y_enf,
        input  load_ready, busy, done, rd_x, rd_y,
               cu_up_x, cu_up_y, cu_x, cu_y, cu_down_x, cu_down_y, cu_is_last
    );
endinterface

// File: rtl/chain_relax_sequencer.sv
// Gauss-Seidel relaxation sequencer: walks points 1..N-1 through an external
// combinational constraint unit, two cycles per point, for a requested number of passes.
module chain_relax_sequencer #(
    parameter int N_POINTS = 8,
    parameter int ITER_W   = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    chain_relax_sequencer_if.slave bus
);
    localparam int IW = $clog2(N_POINTS);
    localparam logic [IW-1:0] LAST = IW'(N_POINTS - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [ITER_W-1:0] pass_q, pass_d;
    logic [31:0]       mem_x_q [N_POINTS];
    logic [31:0]       mem_x_d [N_POINTS];
    logic [31:0]       mem_y_q [N_POINTS];
    logic [31:0]       mem_y_d [N_POINTS];
    logic [31:0]       cu_up_x_q, cu_up_x_d, cu_up_y_q, cu_up_y_d;
    logic [31:0]       cu_x_q, cu_x_d, cu_y_q, cu_y_d;
    logic [31:0]       cu_down_x_q, cu_down_x_d, cu_down_y_q, cu_down_y_d;
    logic              cu_is_last_q, cu_is_last_d;
    logic [31:0]       rd_x_q, rd_x_d, rd_y_q, rd_y_d;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        pass_d       = pass_q;
        mem_x_d      = mem_x_q;
        mem_y_d      = mem_y_q;
        cu_up_x_d    = cu_up_x_q;
        cu_up_y_d    = cu_up_y_q;
        cu_x_d       = cu_x_q;
        cu_y_d       = cu_y_q;
        cu_down_x_d  = cu_down_x_q;
        cu_down_y_d  = cu_down_y_q;
        cu_is_last_d = cu_is_last_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.load_valid && (int'(bus.load_idx) < N_POINTS)) begin
                    mem_x_d[bus.load_idx] = bus.load_x;
                    mem_y_d[bus.load_idx] = bus.load_y;
                end
                if (bus.start) begin
                    pass_d  = bus.iterations;
                    idx_d   = IW'(1);
                    state_d = (bus.iterations == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                cu_up_x_d = mem_x_q[idx_q - 1'b1];
                cu_up_y_d = mem_y_q[idx_q - 1'b1];
                cu_x_d    = mem_x_q[idx_q];
                cu_y_d    = mem_y_q[idx_q];
                // The tail has no lower neighbour; it sees itself as "down".
                if (idx_q == LAST) begin
                    cu_down_x_d  = mem_x_q[idx_q];
                    cu_down_y_d  = mem_y_q[idx_q];
                    cu_is_last_d = 1'b1;
                end else begin
                    cu_down_x_d  = mem_x_q[idx_q + 1'b1];
                    cu_down_y_d  = mem_y_q[idx_q + 1'b1];
                    cu_is_last_d = 1'b0;
                end
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                mem_x_d[idx_q] = bus.cu_x_enf;
                mem_y_d[idx_q] = bus.cu_y_enf;
                if (idx_q < LAST) begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_ISSUE;
                end else begin
                    pass_d = pass_q - 1'b1;
                    if (pass_q == ITER_W'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = IW'(1);
                        state_d = S_ISSUE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Read port sees the pre-edge contents: no forwarding of same-cycle writes.
    always_comb begin
        rd_x_d = '0;
        rd_y_d = '0;
        if (int'(bus.rd_idx) < N_POINTS) begin
            rd_x_d = mem_x_q[bus.rd_idx];
            rd_y_d = mem_y_q[bus.rd_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            pass_q       <= '0;
            cu_up_x_q    <= '0;
            cu_up_y_q    <= '0;
            cu_x_q       <= '0;
            cu_y_q       <= '0;
            cu_down_x_q  <= '0;
            cu_down_y_q  <= '0;
            cu_is_last_q <= 1'b0;
            rd_x_q       <= '0;
            rd_y_q       <= '0;
            for (int i = 0; i < N_POINTS; i++) begin
                mem_x_q[i] <= '0;
                mem_y_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            pass_q       <= pass_d;
            cu_up_x_q    <= cu_up_x_d;
            cu_up_y_q    <= cu_up_y_d;
            cu_x_q       <= cu_x_d;
            cu_y_q       <= cu_y_d;
            cu_down_x_q  <= cu_down_x_d;
            cu_down_y_q  <= cu_down_y_d;
            cu_is_last_q <= cu_is_last_d;
            rd_x_q       <= rd_x_d;
            rd_y_q       <= rd_y_d;
            for (int i = 0; i < N_POINTS; i++) begin
                mem_x_q[i] <= mem_x_d[i];
                mem_y_q[i] <= mem_y_d[i];
            end
        end
    end

    assign bus.load_ready = (state_q == S_IDLE);
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.done       = (state_q == S_DONE);
    assign bus.rd_x       = rd_x_q;
    assign bus.rd_y       = rd_y_q;
    assign bus.cu_up_x    = cu_up_x_q;
    assign bus.cu_up_y    = cu_up_y_q;
    assign bus.cu_x       = cu_x_q;
    assign bus.cu_y       = cu_y_q;
    assign bus.cu_down_x  = cu_down_x_q;
    assign bus.cu_down_y  = cu_down_y_q;
    assign bus.cu_is_last = cu_is_last_q;
endmodule

// File: tb/tb_chain_relax_sequencer.sv
// Randomized bench: a selectable constraint unit plus a reference chain model
// relaxed point by point in plain array code.
module tb_chain_relax_sequencer;
  localparam int N  = 8;
  localparam int IT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   mode = 0;
  int   done_cnt = 0;
  logic [31:0] mx [N];
  logic [31:0] my [N];

  always #5 clk = ~clk;

  chain_relax_sequencer_if #(.N_POINTS(N), .ITER_W(IT)) bus ();
  chain_relax_sequencer #(.N_POINTS(N), .ITER_W(IT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Constraint-unit behaviours selectable by mode.
  function automatic logic [63:0] unit(input int m, input logic [31:0] ux, uy, x, y, dx, dy);
    logic [31:0] ex, ey;
    ex = x; ey = y;
    case (m)
      1: ex = x + 32'd1;
      2: ex = ux + 32'h0001_0000;
      3: begin ex = (ux + (dx >> 1)) ^ 32'h5a5a_0000; ey = (y - uy) + 32'd7; end
      default: ;
    endcase
    return {ex, ey};
  endfunction

  always_comb begin
    {bus.cu_x_enf, bus.cu_y_enf} = unit(mode, bus.cu_up_x, bus.cu_up_y, bus.cu_x, bus.cu_y,
                                        bus.cu_down_x, bus.cu_down_y);
  end

  always @(negedge clk) begin
    if (bus.done) done_cnt++;
    if (rst_n && bus.busy && bus.cu_is_last) begin
      chk("last_down_x", {32'd0, bus.cu_down_x}, {32'd0, bus.cu_x});
      chk("last_down_y", {32'd0, bus.cu_down_y}, {32'd0, bus.cu_y});
    end
  end

  task automatic model_pass(input int k);
    logic [63:0] r;
    for (int p = 0; p < k; p++)
      for (int i = 1; i < N; i++) begin
        int d;
        d = (i == N - 1) ? i : i + 1;
        r = unit(mode, mx[i-1], my[i-1], mx[i], my[i], mx[d], my[d]);
        mx[i] = r[63:32];
        my[i] = r[31:0];
      end
  endtask

  task automatic load(input int i, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    chk("load_ready", {63'd0, bus.load_ready}, 64'd1);
    bus.load_valid = 1'b1; bus.load_idx = 3'(i); bus.load_x = x; bus.load_y = y;
    @(posedge clk); #1;
    bus.load_valid = 1'b0;
    mx[i] = x; my[i] = y;
  endtask

  task automatic readall(input string tag);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      bus.rd_idx = 3'(i);
      @(posedge clk); #1;
      chk({tag, "_x"}, {32'd0, bus.rd_x}, {32'd0, mx[i]});
      chk({tag, "_y"}, {32'd0, bus.rd_y}, {32'd0, my[i]});
    end
  endtask

  task automatic run(input int k, input bit disturb);
    int n, done_n;
    bit gap;
    n = 0; done_n = -1; gap = 0;
    @(negedge clk);
    done_cnt = 0;
    bus.start = 1'b1; bus.iterations = 4'(k);
    @(posedge clk); #1;
    bus.start = 1'b0;
    model_pass(k);
    while (n < 2000) begin
      @(negedge clk);
      n++;
      if (disturb && n == 6) begin
        bus.start = 1'b1; bus.iterations = 4'd3;
        bus.load_valid = 1'b1; bus.load_idx = 3'd2; bus.load_x = 32'hdead_beef;
        chk("ready_busy", {63'd0, bus.load_ready}, 64'd0);
      end
      if (disturb && n == 7) begin bus.start = 1'b0; bus.load_valid = 1'b0; end
      if (!bus.busy) gap = 1;
      if (bus.done) begin done_n = n; break; end
    end
    chk("done_cycle", 64'(done_n), 64'(1 + 2 * (N - 1) * k));
    chk("busy_held", {63'd0, gap}, 64'd0);
    @(negedge clk);
    chk("busy_fall", {63'd0, bus.busy}, 64'd0);
    repeat (3) @(negedge clk);
    chk("done_once", 64'(done_cnt), 64'd1);
  endtask

  initial begin
    bus.load_valid = 0; bus.load_idx = '0; bus.load_x = '0; bus.load_y = '0;
    bus.start = 0; bus.iterations = '0; bus.rd_idx = '0;
    for (int i = 0; i < N; i++) begin mx[i] = '0; my[i] = '0; end
    repeat (2) @(negedge clk);
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_done", {63'd0, bus.done}, 64'd0);
    chk("rst_ready", {63'd0, bus.load_ready}, 64'd1);
    chk("rst_rd", {bus.rd_x, bus.rd_y}, 64'd0);
    chk("rst_cu", {bus.cu_x, bus.cu_down_y}, 64'd0);
    chk("rst_last", {63'd0, bus.cu_is_last}, 64'd0);
    rst_n = 1'b1;
    readall("rd_zero");

    for (int i = 0; i < N; i++) load(i, 32'h0001_0000 * i, 32'h0002_0000 * i);
    readall("rd_load");

    mode = 0; run(2, 0); readall("ident");
    mode = 1; run(3, 0); readall("incr");
    chk("incr_x7", {32'd0, mx[7]}, {32'd0, 32'h0007_0003});

    mode = 2;
    for (int i = 0; i < N; i++) load(i, 32'd0, $urandom);
    run(1, 0); readall("order");
    chk("order_x7", {32'd0, mx[7]}, 64'h0007_0000);

    mode = 1; run(0, 0); readall("k0");
    mode = 0; run(1, 1); readall("guard");

    mode = 3;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++) load(i, $urandom, $urandom);
      run($urandom_range(1, 3), 0);
      readall("rand");
    end

    // Reset in the middle of a K=2 run.
    @(negedge clk);
    bus.start = 1'b1; bus.iterations = 4'd2;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    done_cnt = 0;
    rst_n = 1'b0; #1;
    chk("mid_busy", {63'd0, bus.busy}, 64'd0);
    chk("mid_done", {63'd0, bus.done}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_nodone", 64'(done_cnt), 64'd0);
    for (int i = 0; i < N; i++) begin mx[i] = '0; my[i] = '0; end
    readall("mid_clr");
    for (int i = 0; i < N; i++) load(i, $urandom, $urandom);
    run(2, 0); readall("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/chain_relax_sequencer.md
# chain_relax_sequencer

Sequential driver for the combinational constraint unit used in the rope/chain simulation. It holds a chain of `N_POINTS` 2-D fixed-point positions in a local register file. For each relaxation pass it presents every point's up/self/down neighbours to the constraint unit, captures the enforced position and writes it back in place (Gauss-Seidel order). It runs a requested number of passes under a start/busy/done handshake, with load and read ports toward the host/controller.

## Interface
- `N_POINTS`, default 8: chain length; must be ≥ 2; index width `IW = $clog2(N_POINTS)`.
- `ITER_W`, default 4: width of the iteration-count input.
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `load_valid`  in  1  write request for one point.
- `load_ready`  out  1  high when a write will be accepted (= IDLE).
- `load_idx`  in  IW  point index to write.
- `load_x`, `load_y`  in  32 each  position words (fixed-point, passed through untouched).
- `start`  in  1  begin a run; sampled only in IDLE.
- `iterations`  in  ITER_W  number of passes; captured with `start`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at end of run.
- `rd_idx`  in  IW  read address.
- `rd_x`, `rd_y`  out  32 each  registered read data, one-cycle latency.
- `cu_up_x`, `cu_up_y`, `cu_x`, `cu_y`, `cu_down_x`, `cu_down_y`  out  32 each  registered operands to the constraint unit.
- `cu_is_last`  out  1  high when the operand point is index `N_POINTS-1`.
- `cu_x_enf`, `cu_y_enf`  in  32 each  combinational results from the constraint unit.

## Operation
- Storage: `N_POINTS` × {x, y} registers. Point 0 is the anchor and is never updated by a pass.
- States: IDLE, ISSUE, CAPTURE, DONE.
- IDLE:
  - `load_valid` writes `mem[load_idx] <= {load_x, load_y}`. Writes with `load_idx ≥ N_POINTS` are dropped.
  - On `start`: latch `iterations` into the remaining-pass counter and set `idx <= 1`.
    - If `iterations == 0`, go to DONE.
    - Otherwise go to ISSUE.
  - If `start` and `load_valid` are both high, the load completes in that same cycle and the run begins after it.
- ISSUE: register the operands.
  - `cu_up = mem[idx-1]`, `cu_* = mem[idx]`.
  - `cu_down = mem[idx+1]`; when `idx == N_POINTS-1`, `cu_down = mem[idx]` and `cu_is_last = 1`.
  - Then go to CAPTURE.
- CAPTURE: `cu_*` outputs are stable for the whole cycle. Sample `cu_x_enf`/`cu_y_enf` and write them into `mem[idx]`.
  - If `idx < N_POINTS-1`: `idx++`, go to ISSUE.
  - Else decrement the pass counter. If it is nonzero, set `idx <= 1` and go to ISSUE; if it is zero, go to DONE.
- DONE: `done = 1` for one cycle, then go to IDLE.
- Updates are in place. Point i's up operand is point i-1's value from the current pass.
- `start` while busy is ignored. `load_valid` while busy is ignored, and `load_ready` stays low.
- The read port is live in all states. Mid-run reads return partially relaxed data.
- The block performs no arithmetic on position words. The counters are unsigned and wrap-free by construction.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert): state IDLE, all memory words 0, all `cu_*` 0, `cu_is_last` 0, `rd_x`/`rd_y` 0, `busy` 0, `done` 0, `load_ready` 1.
- Per point: 2 cycles. Per pass: `2·(N_POINTS-1)` cycles.
- `start` sampled at edge t → `busy` high from cycle t+1. `done` is high in cycle `t+1+2·(N_POINTS-1)·K`, where K = `iterations`. `busy` falls the cycle after `done`.
- K = 0: `done` in cycle t+1; memory unchanged.
- Read latency: `rd_idx` at edge t → data valid after edge t+1. A same-cycle write is not forwarded; the old value is returned.
- Reset asserted mid-run: immediately IDLE, memory cleared, no `done` pulse.

## Test plan
- Load and readback: load points 0..7 with x=`0x00010000·i`, y=`0x00020000·i` → `rd_x`/`rd_y` return the exact values one cycle after each `rd_idx`; `load_ready` is 1 throughout.
- Identity unit (`cu_*_enf = cu_*`), N=8, K=2, start at cycle 0 → `done` at cycle 29 only, `busy` cycles 1–29, memory unchanged.
- Increment unit (`cu_x_enf = cu_x + 1`, y identity), K=3 → points 1..7 have x increased by 3, point 0 unchanged.
- Operand ordering, with unit returning `cu_up_x + 0x00010000`, all x=0, K=1 → final x[i] = `i·0x00010000`, confirming the up neighbour is the updated value. For idx=7, `cu_is_last=1` and `cu_down == cu_*`.
- K=0 and busy protection: `start` with `iterations=0` → `done` the next cycle. During a K=1 run, `start` and `load_valid` pulses are ignored, and there is no second `done`.
- Reset mid-run at cycle 5 of a K=2 run → `busy`/`done` 0 immediately, all `rd_*` read 0, and a new start runs normally.
